// File: rtl/psum_round_scheduler_pkg.sv
// Shared types, widths and NoC source-address table for the partial-sum round scheduler.
// The PE address constants mirror the mesh packet format (source field in packet bits [59:56]).
package psum_round_scheduler_pkg;

   localparam int NUM_PE = 5;
   localparam int PSUM_W = 13;
   localparam int ACC_W  = PSUM_W + 3;
   localparam int IDX_W  = 6;
   localparam int PE_W   = 3;

   localparam logic [3:0] ADDR_PE1 = 4'b0001;
   localparam logic [3:0] ADDR_PE2 = 4'b0101;
   localparam logic [3:0] ADDR_PE3 = 4'b0011;
   localparam logic [3:0] ADDR_PE4 = 4'b0111;
   localparam logic [3:0] ADDR_PE5 = 4'b1100;

   typedef enum logic [1:0] {
      PKT_SPIKE  = 2'b00,
      PKT_PSUM   = 2'b01,
      PKT_WEIGHT = 2'b10,
      PKT_CTRL   = 2'b11
   } pkt_type_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_DRAIN   = 3'd2,
      ST_DONE    = 3'd3,
      ST_FIN     = 3'd4
   } state_e;

   typedef struct packed {
      logic            hit;
      logic [PE_W-1:0] idx;
   } pe_sel_t;

   // Unknown sources decode to idx 0 with hit cleared so callers can index safely.
   function automatic pe_sel_t decode_src(input logic [3:0] src);
      pe_sel_t sel;
      sel.hit = 1'b1;
      sel.idx = '0;
      case (src)
         ADDR_PE1: sel.idx = 3'd0;
         ADDR_PE2: sel.idx = 3'd1;
         ADDR_PE3: sel.idx = 3'd2;
         ADDR_PE4: sel.idx = 3'd3;
         ADDR_PE5: sel.idx = 3'd4;
         default:  sel.hit = 1'b0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/psum_round_scheduler_if.sv
// Handshake bundle between the PE partial-sum stream, the scheduler and the downstream accumulator.
// acc_sat exists only when PSUM_SAT_EN is defined.
interface psum_round_scheduler_if
   import psum_round_scheduler_pkg::*;
   ();

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_src;
   logic [PSUM_W-1:0] in_psum;

   logic              acc_valid;
   logic              acc_ready;
   logic [ACC_W-1:0]  acc_sum;
   logic              acc_first;
   logic [IDX_W-1:0]  acc_idx;
`ifdef PSUM_SAT_EN
   logic              acc_sat;
`endif

   logic              done_valid;
   logic              done_ready;

   modport master (
      output in_valid, in_src, in_psum, acc_ready, done_ready,
`ifdef PSUM_SAT_EN
      input  acc_sat,
`endif
      input  in_ready, acc_valid, acc_sum, acc_first, acc_idx, done_valid
   );

   modport slave (
      input  in_valid, in_src, in_psum, acc_ready, done_ready,
`ifdef PSUM_SAT_EN
      output acc_sat,
`endif
      output in_ready, acc_valid, acc_sum, acc_first, acc_idx, done_valid
   );

endinterface

// File: rtl/psum_round_scheduler_pe_buffer.sv
// psum_pe_buffer: per-PE round buffer. Words land at the current write count and are read back
// by round index; a full buffer ignores further writes until the synchronous clear.
module psum_pe_buffer #(
   parameter int DEPTH = 3,
   parameter int W     = 13,
   parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             wr_en_i,
   input  logic [W-1:0]     wr_data_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [W-1:0]     rd_data_o,
   output logic             full_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     mem_q [DEPTH];
   logic             wr_ok;

   assign full_o = (cnt_q == CNT_FULL);
   assign wr_ok  = wr_en_i && !full_o;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (wr_ok)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < DEPTH; i++)
            if (cnt_q == CNT_W'(i))
               mem_q[i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/psum_round_scheduler.sv
// Partial-sum round scheduler: collects one round from all PEs, drains summed words per round
// index, and marks timestep ends. Optional clamp to 2^PSUM_W-1 with acc_sat under PSUM_SAT_EN.
module psum_round_scheduler
   import psum_round_scheduler_pkg::*;
#(
   parameter int PSUM_PER_ROUND   = 3,
   parameter int NEURONS_PER_STEP = 63,
   parameter int NUM_TIMESTEPS    = 10,
   parameter int TS_W             = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   psum_round_scheduler_if.slave  bus,
   output logic [TS_W-1:0]        ts_count,
   output logic                   busy,
   output logic                   err_src
);

   localparam int K_W = (PSUM_PER_ROUND > 1) ? $clog2(PSUM_PER_ROUND) : 1;
   localparam logic [K_W-1:0]   LAST_K   = K_W'(PSUM_PER_ROUND - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS_PER_STEP - 1);
   localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(NUM_TIMESTEPS - 1);

   if (NEURONS_PER_STEP % PSUM_PER_ROUND != 0) begin : g_bad_cfg
      $error("NEURONS_PER_STEP must be a multiple of PSUM_PER_ROUND");
   end

   state_e            state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [IDX_W-1:0]  acc_idx_q, acc_idx_d;
   logic [TS_W-1:0]   ts_q, ts_d;
   logic              acc_valid_q, acc_valid_d;
   logic [ACC_W-1:0]  acc_sum_q, acc_sum_d;
   logic              acc_first_q, acc_first_d;
   logic              done_valid_q, done_valid_d;
   logic              err_src_q, err_src_d;
   logic              busy_q, busy_d;
`ifdef PSUM_SAT_EN
   logic              acc_sat_q, acc_sat_d;
   logic              sat_hit;
`endif

   pe_sel_t           sel;
   logic [NUM_PE-1:0] full;
   logic [NUM_PE-1:0] wr_en;
   logic [PSUM_W-1:0] rd_data [NUM_PE];
   logic              clr;
   logic              in_fire;
   logic [ACC_W-1:0]  sum_raw;
   logic [ACC_W-1:0]  sum_out;

   // Unknown sources are always accepted in COLLECT so they can be dropped and flagged.
   assign sel          = decode_src(bus.in_src);
   assign bus.in_ready = (state_q == ST_COLLECT) && (!sel.hit || !full[sel.idx]);
   assign in_fire      = bus.in_valid && bus.in_ready;

   for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
      assign wr_en[gi] = in_fire && sel.hit && (sel.idx == PE_W'(gi));

      psum_pe_buffer #(
         .DEPTH (PSUM_PER_ROUND),
         .W     (PSUM_W),
         .IDX_W (K_W)
      ) u_buf (
         .clk       (clk),
         .rst_n     (rst_n),
         .clr_i     (clr),
         .wr_en_i   (wr_en[gi]),
         .wr_data_i (bus.in_psum),
         .rd_idx_i  (k_q),
         .rd_data_o (rd_data[gi]),
         .full_o    (full[gi])
      );
   end

   always_comb begin
      sum_raw = '0;
      for (int i = 0; i < NUM_PE; i++)
         sum_raw = sum_raw + ACC_W'(rd_data[i]);
   end

`ifdef PSUM_SAT_EN
   localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'((1 << PSUM_W) - 1);
   assign sat_hit = (sum_raw > SAT_MAX);
   assign sum_out = sat_hit ? SAT_MAX : sum_raw;
`else
   assign sum_out = sum_raw;
`endif

   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      acc_idx_d    = acc_idx_q;
      ts_d         = ts_q;
      acc_valid_d  = acc_valid_q;
      acc_sum_d    = acc_sum_q;
      acc_first_d  = acc_first_q;
      done_valid_d = done_valid_q;
      err_src_d    = in_fire && !sel.hit;
      clr          = 1'b0;
`ifdef PSUM_SAT_EN
      acc_sat_d    = acc_sat_q;
`endif

      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (start) begin
               state_d     = ST_COLLECT;
               ts_d        = '0;
               acc_idx_d   = '0;
               acc_first_d = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (&full) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end
         end
         ST_DRAIN: begin
            // Load a word on the cycle after entry or after each handshake.
            if (!acc_valid_q) begin
               acc_valid_d = 1'b1;
               acc_sum_d   = sum_out;
`ifdef PSUM_SAT_EN
               acc_sat_d   = sat_hit;
`endif
            end else if (bus.acc_ready) begin
               acc_valid_d = 1'b0;
               acc_idx_d   = acc_idx_q + IDX_W'(1);
               if (k_q == LAST_K) begin
                  k_d = '0;
                  clr = 1'b1;
                  if (acc_idx_q == LAST_IDX) begin
                     state_d      = ST_DONE;
                     done_valid_d = 1'b1;
                  end else begin
                     state_d = ST_COLLECT;
                  end
               end else begin
                  k_d = k_q + K_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (done_valid_q && bus.done_ready) begin
               done_valid_d = 1'b0;
               ts_d         = ts_q + TS_W'(1);
               acc_idx_d    = '0;
               acc_first_d  = 1'b0;
               state_d      = (ts_q == LAST_TS) ? ST_FIN : ST_COLLECT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN) || (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         k_q          <= '0;
         acc_idx_q    <= '0;
         ts_q         <= '0;
         acc_valid_q  <= 1'b0;
         acc_sum_q    <= '0;
         acc_first_q  <= 1'b0;
         done_valid_q <= 1'b0;
         err_src_q    <= 1'b0;
         busy_q       <= 1'b0;
`ifdef PSUM_SAT_EN
         acc_sat_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         acc_idx_q    <= acc_idx_d;
         ts_q         <= ts_d;
         acc_valid_q  <= acc_valid_d;
         acc_sum_q    <= acc_sum_d;
         acc_first_q  <= acc_first_d;
         done_valid_q <= done_valid_d;
         err_src_q    <= err_src_d;
         busy_q       <= busy_d;
`ifdef PSUM_SAT_EN
         acc_sat_q    <= acc_sat_d;
`endif
      end
   end

   assign bus.acc_valid  = acc_valid_q;
   assign bus.acc_sum    = acc_sum_q;
   assign bus.acc_first  = acc_first_q;
   assign bus.acc_idx    = acc_idx_q;
   assign bus.done_valid = done_valid_q;
`ifdef PSUM_SAT_EN
   assign bus.acc_sat    = acc_sat_q;
`endif
   assign ts_count       = ts_q;
   assign busy           = busy_q;
   assign err_src        = err_src_q;

endmodule

// File: tb/tb_psum_round_scheduler.sv
// Randomized bench for psum_round_scheduler against a round/timestep reference model.
// Define PSUM_SAT_EN to also exercise the clamp and acc_sat.
module tb_psum_round_scheduler;
   import psum_round_scheduler_pkg::*;

   localparam int PPR = 3;
   localparam int NPS = 63;
   localparam int NTS = 10;
   localparam int TSW = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic [TSW-1:0] ts_count;
   logic           busy;
   logic           err_src;

   psum_round_scheduler_if bus ();

   psum_round_scheduler #(
      .PSUM_PER_ROUND   (PPR),
      .NEURONS_PER_STEP (NPS),
      .NUM_TIMESTEPS    (NTS),
      .TS_W             (TSW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .bus      (bus.slave),
      .ts_count (ts_count),
      .busy     (busy),
      .err_src  (err_src)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-PE words accepted this round, plus neuron/timestep position.
   logic [3:0] pe_addr [5] = '{4'b0001, 4'b0101, 4'b0011, 4'b0111, 4'b1100};
   int cnt [5];
   int pbuf [5][PPR];
   int exp_idx;
   int exp_ts;
   int exp_first;
   int last_lat;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pe_of(input logic [3:0] src);
      for (int p = 0; p < 5; p++)
         if (pe_addr[p] == src) return p;
      return -1;
   endfunction

   function automatic logic [3:0] bad_src();
      logic [3:0] s;
      do s = 4'($urandom_range(0, 15)); while (pe_of(s) >= 0);
      return s;
   endfunction

   task automatic send_word(input logic [3:0] src, input int val);
      int  pe;
      bit  exp_rdy;
      pe      = pe_of(src);
      exp_rdy = (pe < 0) || (cnt[pe] < PPR);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_src   = src;
      bus.in_psum  = 13'(val);
      #1;
      check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (exp_rdy && pe >= 0) begin
         pbuf[pe][cnt[pe]] = val;
         cnt[pe]++;
      end
      check_eq("err_src", 32'(err_src), 32'(exp_rdy && pe < 0));
      $display("in  src=%b val=%0d accepted=%0d", src, val, exp_rdy);
   endtask

   task automatic drain_round(input int stall_k, input int stall_n);
      for (int k = 0; k < PPR; k++) begin
         int raw, exp_sum, w, n;
`ifdef PSUM_SAT_EN
         int exp_sat;
`endif
         raw = 0;
         for (int p = 0; p < 5; p++) raw += pbuf[p][k];
         exp_sum = raw;
`ifdef PSUM_SAT_EN
         exp_sat = 0;
         if (raw > 8191) begin
            exp_sum = 8191;
            exp_sat = 1;
         end
`endif
         w = 0;
         @(negedge clk);
         while (!bus.acc_valid && w < 20) begin
            @(negedge clk);
            w++;
         end
         if (k == 0) last_lat = w;
         check_eq("acc_valid", 32'(bus.acc_valid), 32'd1);
         if (!bus.acc_valid) return;
         check_eq("acc_sum", 32'(bus.acc_sum), 32'(exp_sum));
         check_eq("acc_idx", 32'(bus.acc_idx), 32'(exp_idx));
         check_eq("acc_first", 32'(bus.acc_first), 32'(exp_first));
`ifdef PSUM_SAT_EN
         check_eq("acc_sat", 32'(bus.acc_sat), 32'(exp_sat));
`endif
         $display("acc idx=%0d sum=%0d first=%0d ts=%0d", bus.acc_idx, bus.acc_sum, bus.acc_first, ts_count);
         n = (k == stall_k) ? stall_n : $urandom_range(0, 2);
         for (int j = 0; j < n; j++) begin
            if (j > 0) @(negedge clk);
            if (k == stall_k && j == 0) begin
               bus.in_valid = 1'b1;
               bus.in_src   = pe_addr[0];
               start        = 1'b1;
               #1;
               check_eq("in_ready_drain", 32'(bus.in_ready), 32'd0);
               bus.in_valid = 1'b0;
            end else begin
               start = 1'b0;
            end
            check_eq("hold_valid", 32'(bus.acc_valid), 32'd1);
            check_eq("hold_sum", 32'(bus.acc_sum), 32'(exp_sum));
            check_eq("hold_idx", 32'(bus.acc_idx), 32'(exp_idx));
            @(negedge clk);
         end
         start         = 1'b0;
         bus.acc_ready = 1'b1;
         @(posedge clk);
         #1;
         bus.acc_ready = 1'b0;
         exp_idx++;
         check_eq("acc_gap", 32'(bus.acc_valid), 32'd0);
         check_eq("idx_inc", 32'(bus.acc_idx), 32'(exp_idx));
      end
      for (int p = 0; p < 5; p++) cnt[p] = 0;
      check_eq("done_rise", 32'(bus.done_valid), 32'(exp_idx == NPS));
   endtask

   task automatic done_step(input int hold);
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.done_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("done_valid", 32'(bus.done_valid), 32'd1);
      check_eq("done_idx", 32'(bus.acc_idx), 32'(NPS));
      for (int j = 0; j < hold; j++) begin
         @(negedge clk);
         check_eq("done_hold", 32'(bus.done_valid), 32'd1);
         check_eq("done_ts_hold", 32'(ts_count), 32'(exp_ts));
      end
      bus.done_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.done_ready = 1'b0;
      exp_ts++;
      exp_idx   = 0;
      exp_first = 0;
      check_eq("ts_count", 32'(ts_count), 32'(exp_ts));
      check_eq("first_clr", 32'(bus.acc_first), 32'd0);
      check_eq("done_drop", 32'(bus.done_valid), 32'd0);
      check_eq("idx_clr", 32'(bus.acc_idx), 32'd0);
      check_eq("busy_done", 32'(busy), 32'(exp_ts != NTS));
      $display("done ts_count=%0d busy=%0d", ts_count, busy);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      exp_ts    = 0;
      exp_idx   = 0;
      exp_first = 1;
      for (int p = 0; p < 5; p++) cnt[p] = 0;
      check_eq("start_busy", 32'(busy), 32'd1);
      check_eq("start_first", 32'(bus.acc_first), 32'd1);
      check_eq("start_ts", 32'(ts_count), 32'd0);
   endtask

   task automatic fill_fixed();
      for (int n = 0; n < 5; n++)
         for (int k = 0; k < PPR; k++)
            send_word(pe_addr[n], 10 * (n + 1) + k);
   endtask

   task automatic fill_random();
      int order [15];
      int tmp, j;
      for (int i = 0; i < 15; i++) order[i] = i / PPR;
      for (int i = 14; i > 0; i--) begin
         j        = $urandom_range(0, i);
         tmp      = order[i];
         order[i] = order[j];
         order[j] = tmp;
      end
      for (int i = 0; i < 15; i++) begin
         if ($urandom_range(0, 7) == 0) send_word(bad_src(), $urandom_range(0, 8191));
         if ($urandom_range(0, 5) == 0) begin
            for (int p = 0; p < 5; p++)
               if (cnt[p] == PPR) begin
                  send_word(pe_addr[p], $urandom_range(0, 8191));
                  break;
               end
         end
         send_word(pe_addr[order[i]], $urandom_range(0, 8191));
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      check_eq({tag, "_acc_valid"}, 32'(bus.acc_valid), 32'd0);
      check_eq({tag, "_done_valid"}, 32'(bus.done_valid), 32'd0);
      check_eq({tag, "_err_src"}, 32'(err_src), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_acc_first"}, 32'(bus.acc_first), 32'd0);
      check_eq({tag, "_acc_sum"}, 32'(bus.acc_sum), 32'd0);
      check_eq({tag, "_acc_idx"}, 32'(bus.acc_idx), 32'd0);
      check_eq({tag, "_ts_count"}, 32'(ts_count), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst_n          = 1'b0;
      start          = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_src     = 4'b0000;
      bus.in_psum    = '0;
      bus.acc_ready  = 1'b0;
      bus.done_ready = 1'b0;
      for (int p = 0; p < 5; p++) cnt[p] = 0;
      exp_idx = 0; exp_ts = 0; exp_first = 0; last_lat = 0;

      repeat (3) @(negedge clk);
      check_idle("rst");
      rst_n        = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_src   = pe_addr[0];
      @(negedge clk);
      check_eq("idle_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;

      // Fixed round: PE n word k = 10n+k -> sums 150, 155, 160.
      do_start();
      fill_fixed();
      drain_round(-1, 0);
      check_eq("drain_lat", 32'(last_lat), 32'd2);

      // Interleaved sources with an extra PE3 word once it is full.
      for (int k = 0; k < PPR; k++)
         for (int n = 0; n < 5; n++) begin
            send_word(pe_addr[n], 10 * (n + 1) + k);
            if (k == PPR - 1 && n == 2) send_word(pe_addr[2], 999);
         end
      drain_round(-1, 0);

      // Unknown source: accepted, dropped, one-cycle err_src.
      send_word(4'b1111, 77);
      @(posedge clk);
      #1;
      check_eq("err_src_pulse", 32'(err_src), 32'd0);
      fill_random();
      drain_round(-1, 0);

      // acc_ready held low mid-drain, with stray in_valid/start.
      fill_random();
      drain_round(1, 4);

      for (int r = 4; r < NPS / PPR; r++) begin
         fill_random();
         drain_round(-1, 0);
      end
      done_step(5);

      for (int t = 1; t < NTS; t++) begin
         for (int r = 0; r < NPS / PPR; r++) begin
            fill_random();
            drain_round(-1, 0);
         end
         done_step($urandom_range(0, 3));
      end
      @(negedge clk);
      check_eq("fin_busy", 32'(busy), 32'd0);
      check_eq("fin_ts", 32'(ts_count), 32'(NTS));
      bus.in_valid = 1'b1;
      bus.in_src   = pe_addr[1];
      #1;
      check_eq("fin_in_ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;

      // Restart from FIN, then reset while a word is pending in DRAIN.
      do_start();
      fill_random();
      w = 0;
      @(negedge clk);
      while (!bus.acc_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      check_eq("pre_rst_valid", 32'(bus.acc_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check_idle("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      fill_fixed();
      drain_round(-1, 0);

`ifdef PSUM_SAT_EN
      for (int n = 0; n < 5; n++)
         for (int k = 0; k < PPR; k++)
            send_word(pe_addr[n], 8191);
      drain_round(-1, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
